// File: rtl/pu_mac_stream_if.sv
// Stream bundle for the MAC processing unit: input beat handshake and result handshake.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer flows back combinationally to in_ready.
//
// Signals:
//   in_valid / in_ready   beat handshake; in_data, in_weight, in_last travel with it
//   out_valid / out_ready result handshake; out_data, out_ovf travel with it
// Modports: master = producer/consumer side (the bench), slave = the MAC unit.
interface pu_mac_stream_if #(
   parameter int WIDTH = 5,
   parameter int LANES = 4,
   parameter int ACC_W = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*WIDTH-1:0]   in_data;
   logic [LANES*WIDTH-1:0]   in_weight;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic [ACC_W-1:0]         out_data;
   logic                     out_ovf;

   modport master (
      output in_valid, in_data, in_weight, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_weight, in_last, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/pu_mac_stream.sv
// Pipelined multiply-accumulate unit: per-beat lane products, adder tree, packet accumulator.
// Latency: result valid two edges after the last beat of a packet is accepted.
// Backpressure: a held, unconsumed result freezes the whole pipeline and drops in_ready.
//
// Ports: clk, rst (synchronous, active high), bus (pu_mac_stream_if.slave) carrying the
//   input beat stream (LANES data/weight pairs + in_last) and the result stream
//   (out_data packet sum + sticky out_ovf).
// Option: define PU_SATURATE_EN to clamp the accumulator at 2^ACC_W-1 on overflow
//   instead of wrapping.
// Parameter constraints: LANES is a power of two in 2..16, ACC_W >= 2*WIDTH + log2(LANES).
module pu_mac_stream #(
   parameter int WIDTH = 5,
   parameter int LANES = 4,
   parameter int ACC_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   pu_mac_stream_if.slave     bus
);

   localparam int PW    = 2 * WIDTH;
   localparam int SUM_W = PW + $clog2(LANES);
   localparam int AW1   = ACC_W + 1;

   // Global advance: every stage moves together unless a result is stuck in the output register.
   logic adv;
   logic accept;

   logic [PW-1:0]    s1_prod [LANES];
   logic             s1_valid;
   logic             s1_last;

   logic [SUM_W-1:0] tree_sum;
   logic [SUM_W-1:0] s2_sum;
   logic             s2_valid;
   logic             s2_last;

   logic [ACC_W-1:0] acc;
   logic             acc_ovf;
   logic             first;

   logic [AW1-1:0]   acc_sum;
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W-1:0] acc_res;
   logic             overflow;
   logic             ovf_next;

   logic             out_valid_q;
   logic [ACC_W-1:0] out_data_q;
   logic             out_ovf_q;

   assign adv          = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && adv;
   assign bus.in_ready = adv;

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;

   // Stage 1: lane products. Product registers need no reset; they are qualified by s1_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
      end else if (adv) begin
         s1_valid <= accept;
         s1_last  <= bus.in_last;
         if (accept) begin
            for (int i = 0; i < LANES; i++) begin
               s1_prod[i] <= PW'(bus.in_data[i*WIDTH +: WIDTH]) * PW'(bus.in_weight[i*WIDTH +: WIDTH]);
            end
         end
      end
   end

   // Adder tree, zero-extended so the full lane sum never wraps.
   always_comb begin
      tree_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         tree_sum = tree_sum + SUM_W'(s1_prod[i]);
      end
   end

   // Stage 2: registered beat sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_sum   <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_last  <= s1_last;
         s2_sum   <= tree_sum;
      end
   end

   // Accumulate step. The first beat of a packet starts from zero and a clean overflow flag,
   // which is what lets a reset or a completed packet discard all earlier history.
   always_comb begin
      acc_base = first ? '0 : acc;
      acc_sum  = AW1'(acc_base) + AW1'(s2_sum);
      overflow = acc_sum[ACC_W];
      ovf_next = (first ? 1'b0 : acc_ovf) | overflow;
`ifdef PU_SATURATE_EN
      // Once clamped, any further non-zero addition overflows again and re-clamps.
      acc_res  = overflow ? '1 : acc_sum[ACC_W-1:0];
`else
      acc_res  = acc_sum[ACC_W-1:0];
`endif
   end

   // Stage 3 and output register. The last beat bypasses acc straight into out_data, so
   // acc only ever holds partial sums of the packet in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         acc_ovf     <= 1'b0;
         first       <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
      end else if (adv) begin
         out_valid_q <= s2_valid && s2_last;
         if (s2_valid) begin
            if (!s2_last) begin
               acc     <= acc_res;
               acc_ovf <= ovf_next;
               first   <= 1'b0;
            end else begin
               out_data_q <= acc_res;
               out_ovf_q  <= ovf_next;
               first      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pu_mac_stream.sv
// Bench for pu_mac_stream: two instances (ACC_W=16 and ACC_W=12) driven with identical beats.
// Latency: checks arrival two edges after the last beat and a scoreboard of packet results.
// Backpressure: out_ready is held low or randomised; results must arrive in order, once each.
module tb_pu_mac_stream;

   localparam int W  = 5;
   localparam int L  = 4;
   localparam int AH = 16;
   localparam int AL = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pu_mac_stream_if #(.WIDTH(W), .LANES(L), .ACC_W(AH)) bh ();
   pu_mac_stream_if #(.WIDTH(W), .LANES(L), .ACC_W(AL)) bl ();

   pu_mac_stream #(.WIDTH(W), .LANES(L), .ACC_W(AH)) dut_h (.clk(clk), .rst(rst), .bus(bh));
   pu_mac_stream #(.WIDTH(W), .LANES(L), .ACC_W(AL)) dut_l (.clk(clk), .rst(rst), .bus(bl));

   int checks = 0;
   int errors = 0;

   logic [L*W-1:0] cur_d = '0;
   logic [L*W-1:0] cur_w = '0;
   logic           cur_v = 1'b0;
   logic           cur_l = 1'b0;
   logic           cur_r = 1'b1;

   // Reference model: exact packet totals in plain integers, results derived from the totals.
   longint tot = 0;
   longint qh_d[$];
   longint ql_d[$];
   bit     qh_o[$];
   bit     ql_o[$];

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint beat_sum(input logic [L*W-1:0] d, input logic [L*W-1:0] w);
      longint s = 0;
      for (int i = 0; i < L; i++) begin
         s += longint'(d[i*W +: W]) * longint'(w[i*W +: W]);
      end
      return s;
   endfunction

   function automatic longint res_of(input longint total, input int aw);
      longint maxv = (longint'(1) << aw) - 1;
`ifdef PU_SATURATE_EN
      return (total > maxv) ? maxv : total;
`else
      return total % (longint'(1) << aw);
`endif
   endfunction

   function automatic logic [L*W-1:0] pack4(input int a, input int b, input int c, input int e);
      logic [L*W-1:0] v;
      v = {W'(e), W'(c), W'(b), W'(a)};
      return v;
   endfunction

   function automatic logic [L*W-1:0] rand_vec();
      logic [L*W-1:0] v;
      for (int i = 0; i < L; i++) v[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
      return v;
   endfunction

   task automatic apply();
      bh.in_valid = cur_v;  bl.in_valid = cur_v;
      bh.in_data  = cur_d;  bl.in_data  = cur_d;
      bh.in_weight = cur_w; bl.in_weight = cur_w;
      bh.in_last  = cur_l;  bl.in_last  = cur_l;
      bh.out_ready = cur_r; bl.out_ready = cur_r;
   endtask

   // One clock: settle inputs, observe both handshakes at the falling edge, update the model,
   // then return just after the rising edge.
   task automatic cycle();
      longint s;
      apply();
      @(negedge clk);
      if (!rst && bh.out_valid && bh.out_ready) begin
         chk("pending_h", (qh_d.size() != 0) ? 1 : 0, 1);
         if (qh_d.size() != 0) begin
            chk("data_h", longint'(bh.out_data), qh_d.pop_front());
            chk("ovf_h", longint'(bh.out_ovf), longint'(qh_o.pop_front()));
         end
      end
      if (!rst && bl.out_valid && bl.out_ready) begin
         chk("pending_l", (ql_d.size() != 0) ? 1 : 0, 1);
         if (ql_d.size() != 0) begin
            chk("data_l", longint'(bl.out_data), ql_d.pop_front());
            chk("ovf_l", longint'(bl.out_ovf), longint'(ql_o.pop_front()));
         end
      end
      if (!rst && cur_v && bh.in_ready) begin
         s = beat_sum(cur_d, cur_w);
         tot += s;
         if (cur_l) begin
            qh_d.push_back(res_of(tot, AH)); qh_o.push_back(tot > (longint'(1) << AH) - 1);
            ql_d.push_back(res_of(tot, AL)); ql_o.push_back(tot > (longint'(1) << AL) - 1);
            tot = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [L*W-1:0] d, input logic [L*W-1:0] w, input logic last);
      cur_v = 1'b1; cur_d = d; cur_w = w; cur_l = last;
      cycle();
      cur_v = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      cur_v = 1'b0;
      cur_r = 1'b1;
      while ((qh_d.size() != 0 || ql_d.size() != 0) && n < 60) begin
         cycle();
         n++;
      end
      chk(tag, longint'(qh_d.size() + ql_d.size()), 0);
      // A few idle cycles so a duplicated result would still be caught.
      repeat (3) cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cur_v = 1'b0;
      cycle();
      rst = 1'b0;
      tot = 0;
      qh_d.delete(); qh_o.delete(); ql_d.delete(); ql_o.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [L*W-1:0] ones;
      int n;
      ones = '1;
      cur_r = 1'b1;
      apply();

      // Reset state
      do_reset();
      chk("rst_out_valid", longint'(bh.out_valid), 0);
      chk("rst_out_data", longint'(bh.out_data), 0);
      chk("rst_out_ovf", longint'(bh.out_ovf), 0);
      chk("rst_in_ready", longint'(bh.in_ready), 1);
      chk("rst_out_valid_l", longint'(bl.out_valid), 0);

      // Single beat: 1*5+2*6+3*7+4*8 = 70, valid from edge n+2
      beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
      chk("lat_n0", longint'(bh.out_valid), 0);
      cycle();
      chk("lat_n1", longint'(bh.out_valid), 0);
      cycle();
      chk("lat_n2", longint'(bh.out_valid), 1);
      chk("single_70", longint'(bh.out_data), 70);
      chk("single_ovf", longint'(bh.out_ovf), 0);
      drain("drain_single");

      // Three-beat packet of all-31 lanes: 3 * 3844 = 11532
      beat(ones, ones, 1'b0);
      beat(ones, ones, 1'b0);
      beat(ones, ones, 1'b1);
      n = 0;
      while (!bh.out_valid && n < 20) begin cycle(); n++; end
      chk("three_seen", longint'(bh.out_valid), 1);
      chk("three_11532", longint'(bh.out_data), 11532);
      chk("three_ovf", longint'(bh.out_ovf), 0);
      drain("drain_three");

      // Overflow on the 12-bit instance: 7688
      beat(ones, ones, 1'b0);
      beat(ones, ones, 1'b1);
      n = 0;
      while (!bl.out_valid && n < 20) begin cycle(); n++; end
      chk("ovf_seen", longint'(bl.out_valid), 1);
`ifdef PU_SATURATE_EN
      chk("ovf_data12", longint'(bl.out_data), 4095);
`else
      chk("ovf_data12", longint'(bl.out_data), 3592);
`endif
      chk("ovf_flag12", longint'(bl.out_ovf), 1);
      chk("ovf_data16", longint'(bh.out_data), 7688);
      drain("drain_ovf");
      beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1);
      n = 0;
      while (!bl.out_valid && n < 20) begin cycle(); n++; end
      chk("after_ovf_data", longint'(bl.out_data), 4);
      chk("after_ovf_flag", longint'(bl.out_ovf), 0);
      drain("drain_after_ovf");

      // Backpressure: 70 then 4, consumer stalls 5 cycles, a third beat waits at the input
      cur_r = 1'b0;
      beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
      beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1);
      cycle();
      cur_v = 1'b1; cur_d = pack4(2, 0, 0, 0); cur_w = pack4(3, 0, 0, 0); cur_l = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", longint'(bh.in_ready), 0);
         chk("bp_valid", longint'(bh.out_valid), 1);
         chk("bp_hold_70", longint'(bh.out_data), 70);
         cycle();
      end
      cur_r = 1'b1;
      cycle();
      cur_v = 1'b0;
      drain("drain_bp");

      // Reset mid-packet discards partial sums
      beat(rand_vec(), rand_vec(), 1'b0);
      beat(rand_vec(), rand_vec(), 1'b0);
      do_reset();
      chk("mid_rst_valid", longint'(bh.out_valid), 0);
      beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1);
      n = 0;
      while (!bh.out_valid && n < 20) begin cycle(); n++; end
      chk("mid_rst_data", longint'(bh.out_data), 4);
      chk("mid_rst_data_l", longint'(bl.out_data), 4);
      drain("drain_rst");

      // Streaming: 16 back-to-back single-beat packets, one result per cycle
      cur_r = 1'b1;
      for (int i = 0; i < 19; i++) begin
         cur_v = (i < 16);
         cur_d = rand_vec(); cur_w = rand_vec(); cur_l = 1'b1;
         cycle();
         if (i >= 2 && i <= 17) chk("stream_valid", longint'(bh.out_valid), 1);
         if (i == 18) chk("stream_end", longint'(bh.out_valid), 0);
      end
      cur_v = 1'b0;
      drain("drain_stream");

      // Random packets with random gaps and random consumer stalls
      for (int i = 0; i < 400; i++) begin
         cur_v = ($urandom_range(0, 3) != 0);
         cur_l = ($urandom_range(0, 2) == 0);
         cur_d = ($urandom_range(0, 4) == 0) ? ones : rand_vec();
         cur_w = ($urandom_range(0, 4) == 0) ? ones : rand_vec();
         cur_r = ($urandom_range(0, 3) != 0);
         cycle();
      end
      // Close any open packet so every result is expected to leave.
      cur_r = 1'b1;
      n = 0;
      cur_v = 1'b1; cur_l = 1'b1; cur_d = rand_vec(); cur_w = rand_vec();
      while (tot != 0 && n < 20) begin cycle(); n++; end
      cur_v = 1'b0;
      drain("drain_random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
